// File: rtl/ysyx_210544_axi_io_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_210544_axi_io_arbiter_if
// Description : Bundle of the requester-side and AXI-io-side signals shared
//               by the round-robin io arbiter and its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface ysyx_210544_axi_io_arbiter_if #(
  parameter int N     = 3,
  parameter int IDX_W = 2
);
  // Requester side (one slice per requester)
  logic [N-1:0]     i_req_valid;
  logic [N-1:0]     i_req_op;
  logic [N*64-1:0]  i_req_addr;
  logic [N*3-1:0]   i_req_size;
  logic [N*8-1:0]   i_req_blks;
  logic [N*512-1:0] i_req_wdata;
  logic [N-1:0]     o_req_ready;
  logic [511:0]     o_req_rdata;
  logic [IDX_W-1:0] o_grant_idx;
  logic             o_busy;

  // AXI master side
  logic             o_axi_io_valid;
  logic             o_axi_io_op;
  logic [63:0]      o_axi_io_addr;
  logic [2:0]       o_axi_io_size;
  logic [7:0]       o_axi_io_blks;
  logic [511:0]     o_axi_io_wdata;
  logic             i_axi_io_ready;
  logic [511:0]     i_axi_io_rdata;

  // Arbiter view
  modport slave (
    input  i_req_valid, i_req_op, i_req_addr, i_req_size, i_req_blks, i_req_wdata,
    input  i_axi_io_ready, i_axi_io_rdata,
    output o_req_ready, o_req_rdata, o_grant_idx, o_busy,
    output o_axi_io_valid, o_axi_io_op, o_axi_io_addr, o_axi_io_size,
    output o_axi_io_blks, o_axi_io_wdata
  );

  // Environment view (requesters plus AXI master)
  modport master (
    output i_req_valid, i_req_op, i_req_addr, i_req_size, i_req_blks, i_req_wdata,
    output i_axi_io_ready, i_axi_io_rdata,
    input  o_req_ready, o_req_rdata, o_grant_idx, o_busy,
    input  o_axi_io_valid, o_axi_io_op, o_axi_io_addr, o_axi_io_size,
    input  o_axi_io_blks, o_axi_io_wdata
  );
endinterface
`default_nettype wire

// File: rtl/ysyx_210544_axi_io_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_210544_axi_io_arbiter
// Description : Round-robin arbiter sharing one AXI io request channel among
//               N cache-side requesters. One transaction outstanding at a
//               time; request fields are registered and held until the AXI
//               master completes, then a one-cycle ready pulse is returned.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_210544_axi_io_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic                          clk,
  input  logic                          rst,   // asynchronous, active-low
  ysyx_210544_axi_io_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q,   ptr_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic             busy_q,  busy_d;
  logic             valid_q, valid_d;
  logic             op_q,    op_d;
  logic [63:0]      addr_q,  addr_d;
  logic [2:0]       size_q,  size_d;
  logic [7:0]       blks_q,  blks_d;
  logic [511:0]     wdata_q, wdata_d;
  logic [N-1:0]     ready_q, ready_d;
  logic [511:0]     rdata_q, rdata_d;

  logic             win_found;
  logic [IDX_W-1:0] win_idx;

  // (base + off) mod N, valid for base < N and off <= N
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input int unsigned      off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= 32'(N)) s = s - 32'(N);
    return IDX_W'(s);
  endfunction

  // First valid requester scanning ptr, ptr+1, ... (mod N)
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < N; k++) begin
      if (!win_found && bus.i_req_valid[wrap_add(ptr_q, unsigned'(k))]) begin
        win_found = 1'b1;
        win_idx   = wrap_add(ptr_q, unsigned'(k));
      end
    end
  end

  // State and output registers; async reset clears everything
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      op_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      blks_q  <= '0;
      wdata_q <= '0;
      ready_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      blks_q  <= blks_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state and next-output logic; everything holds unless a state acts
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    op_d    = op_q;
    addr_d  = addr_q;
    size_d  = size_q;
    blks_d  = blks_q;
    wdata_d = wdata_q;
    ready_d = ready_q;
    rdata_d = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d = S_BUSY;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          grant_d = win_idx;
          ptr_d   = wrap_add(win_idx, 32'd1);
          op_d    = bus.i_req_op[win_idx];
          addr_d  = bus.i_req_addr[win_idx*64 +: 64];
          size_d  = bus.i_req_size[win_idx*3 +: 3];
          blks_d  = bus.i_req_blks[win_idx*8 +: 8];
          wdata_d = bus.i_req_wdata[win_idx*512 +: 512];
        end
      end
      S_BUSY: begin
        // Request fields stay frozen; only the AXI completion moves us on
        if (valid_q && bus.i_axi_io_ready) begin
          state_d          = S_DONE;
          valid_d          = 1'b0;
          rdata_d          = bus.i_axi_io_rdata;
          ready_d          = '0;
          ready_d[grant_q] = 1'b1;
        end
      end
      S_DONE: begin
        // Dead cycle: ends the ready pulse and lets the requester drop valid
        state_d = S_IDLE;
        ready_d = '0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.o_req_ready    = ready_q;
  assign bus.o_req_rdata    = rdata_q;
  assign bus.o_grant_idx    = grant_q;
  assign bus.o_busy         = busy_q;
  assign bus.o_axi_io_valid = valid_q;
  assign bus.o_axi_io_op    = op_q;
  assign bus.o_axi_io_addr  = addr_q;
  assign bus.o_axi_io_size  = size_q;
  assign bus.o_axi_io_blks  = blks_q;
  assign bus.o_axi_io_wdata = wdata_q;

endmodule
`default_nettype wire
